// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter and access sequencer for the
// shared 8-bit memory bus. Master 0 is the core fetch/execute path, master 1
// the external loader/debug port.
//
// Parameters:
//   WAIT  extra access cycles after the first (0..15)
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata     master X request and access attributes
//   mX_lock                  keep the bus for another access (lock build only)
//   mX_gnt                   master X owns the bus (ACCESS and DONE)
//   mX_ack                   one-cycle completion pulse (DONE)
//   rdata                    data of the last completed read
//   mem_addr/wdata/rdata     memory address and data path
//   mem_ena/read/write       memory enable and strobes (ACCESS only)
//   busy                     arbiter not in IDLE
// Configuration:
//   MEM_ARBITER_LOCK_EN      when defined, an owner holding lock and req at
//                            DONE goes straight back to ACCESS.
module mem_arbiter #(
  parameter int WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  input  logic       m0_lock,
  output logic       m0_gnt,
  output logic       m0_ack,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  input  logic       m1_lock,
  output logic       m1_gnt,
  output logic       m1_ack,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       mem_ena,
  output logic       mem_read,
  output logic       mem_write,
  output logic       busy
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last;      // winner of the previous arbitrated grant
  logic       owner;     // master currently holding the bus
  logic       we_r;
  logic [7:0] addr_r, wdata_r;
  logic       load;      // capture attributes and start an access
  logic       arb;       // load came from IDLE arbitration (updates last)
  logic       win;
  logic       relock;

`ifdef MEM_ARBITER_LOCK_EN
  assign relock = owner ? (m1_lock & m1_req) : (m0_lock & m0_req);
`else
  // Lock inputs exist on the port list but have no effect in this build.
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign relock      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    arb       = 1'b0;
    win       = owner;
    case (state)
      IDLE: begin
        if (m0_req | m1_req) begin
          // On a tie the master that lost last time goes first.
          win       = (m0_req & m1_req) ? ~last : m1_req;
          load      = 1'b1;
          arb       = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: if (cnt == 4'd0) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if (relock) begin
          load      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata   <= '0;
    end else begin
      if (load) begin
        owner   <= win;
        we_r    <= win ? m1_we    : m0_we;
        addr_r  <= win ? m1_addr  : m0_addr;
        wdata_r <= win ? m1_wdata : m0_wdata;
        cnt     <= CNT_LOAD;
        if (arb) last <= win;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Last strobe cycle of a read: memory data is valid now.
      if (state == ACCESS && cnt == 4'd0 && !we_r) rdata <= mem_rdata;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  logic acc, done;
  assign acc       = (state == ACCESS);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign m0_gnt    = busy & ~owner;
  assign m1_gnt    = busy &  owner;
  assign m0_ack    = done & ~owner;
  assign m1_ack    = done &  owner;
  assign mem_ena   = acc;
  assign mem_read  = acc & ~we_r;
  assign mem_write = acc &  we_r;
  assign mem_addr  = acc ? addr_r  : 8'h00;
  assign mem_wdata = acc ? wdata_r : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int NI = 3;

  function automatic int wait_of(int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  // Memory contents: a fixed function of the address.
  function automatic logic [7:0] mem_f(logic [7:0] a);
    return a ^ 8'h4A;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       req_d [2];
  logic       we_d  [2];
  logic       lock_d[2];
  logic [7:0] addr_d[2];
  logic [7:0] wdata_d[2];

  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  assign m0_req = req_d[0];  assign m0_we = we_d[0];  assign m0_lock = lock_d[0];
  assign m0_addr = addr_d[0]; assign m0_wdata = wdata_d[0];
  assign m1_req = req_d[1];  assign m1_we = we_d[1];  assign m1_lock = lock_d[1];
  assign m1_addr = addr_d[1]; assign m1_wdata = wdata_d[1];

  logic       m0_gnt_a[NI], m0_ack_a[NI], m1_gnt_a[NI], m1_ack_a[NI];
  logic       mem_ena_a[NI], mem_read_a[NI], mem_write_a[NI], busy_a[NI];
  logic [7:0] rdata_a[NI], mem_addr_a[NI], mem_wdata_a[NI], mem_rdata_a[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign mem_rdata_a[g] = mem_f(mem_addr_a[g]);
    mem_arbiter #(.WAIT(g == 0 ? 1 : (g == 1 ? 0 : 15))) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_gnt(m0_gnt_a[g]), .m0_ack(m0_ack_a[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_gnt(m1_gnt_a[g]), .m1_ack(m1_ack_a[g]),
      .rdata(rdata_a[g]), .mem_addr(mem_addr_a[g]), .mem_wdata(mem_wdata_a[g]),
      .mem_rdata(mem_rdata_a[g]), .mem_ena(mem_ena_a[g]), .mem_read(mem_read_a[g]),
      .mem_write(mem_write_a[g]), .busy(busy_a[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: transaction timeline relative to the grant edge.
  int         k_sel  = 0;
  bit         chk_en = 0;
  int         t, g_e, nfree, last_m, own, win_m, w_m;
  bit         gr_m;
  logic       cw;
  logic [7:0] ca, cd, exp_rd;
  logic       e_acc, e_done;
  logic       eg0, eg1, ea0, ea1, ebusy, erd, ewr;
  logic [7:0] eaddr;

  always begin
    @(posedge clk);
    if (!rst) begin
      t = 0; g_e = -100; nfree = 0; last_m = 1; own = 0;
      exp_rd = 8'h00; e_acc = 1'b0; e_done = 1'b0; cw = 1'b0; ca = 8'h00; cd = 8'h00;
    end else begin
      w_m = wait_of(k_sel);
      t++;
      if (g_e >= 0 && t == g_e + w_m + 1 && !cw) exp_rd = mem_f(ca);
      gr_m  = 1'b0;
      win_m = own;
`ifdef MEM_ARBITER_LOCK_EN
      if (g_e >= 0 && t == g_e + w_m + 2 &&
          (own == 1 ? (m1_lock && m1_req) : (m0_lock && m0_req))) gr_m = 1'b1;
`endif
      if (!gr_m && t >= nfree && (m0_req || m1_req)) begin
        gr_m   = 1'b1;
        win_m  = (m0_req && m1_req) ? 1 - last_m : (m1_req ? 1 : 0);
        last_m = win_m;
      end
      if (gr_m) begin
        g_e = t; own = win_m; nfree = t + w_m + 3;
        cw = (own == 1) ? m1_we    : m0_we;
        ca = (own == 1) ? m1_addr  : m0_addr;
        cd = (own == 1) ? m1_wdata : m0_wdata;
      end
      e_acc  = (g_e >= 0) && (t - g_e <= w_m);
      e_done = (g_e >= 0) && (t - g_e == w_m + 1);
    end
    #1;
    if (chk_en) begin
      ebusy = e_acc | e_done;
      eg0 = ebusy & (own == 0);  eg1 = ebusy & (own == 1);
      ea0 = e_done & (own == 0); ea1 = e_done & (own == 1);
      erd = e_acc & ~cw;         ewr = e_acc & cw;
      eaddr = e_acc ? ca : 8'h00;
      checks++; if (m0_gnt_a[k_sel] !== eg0) begin errors++;
        $display("FAIL m0_gnt k%0d t=%0d got %b exp %b", k_sel, t, m0_gnt_a[k_sel], eg0); end
      checks++; if (m1_gnt_a[k_sel] !== eg1) begin errors++;
        $display("FAIL m1_gnt k%0d t=%0d got %b exp %b", k_sel, t, m1_gnt_a[k_sel], eg1); end
      checks++; if (m0_ack_a[k_sel] !== ea0) begin errors++;
        $display("FAIL m0_ack k%0d t=%0d got %b exp %b", k_sel, t, m0_ack_a[k_sel], ea0); end
      checks++; if (m1_ack_a[k_sel] !== ea1) begin errors++;
        $display("FAIL m1_ack k%0d t=%0d got %b exp %b", k_sel, t, m1_ack_a[k_sel], ea1); end
      checks++; if (busy_a[k_sel] !== ebusy) begin errors++;
        $display("FAIL busy k%0d t=%0d got %b exp %b", k_sel, t, busy_a[k_sel], ebusy); end
      checks++; if (mem_ena_a[k_sel] !== e_acc) begin errors++;
        $display("FAIL mem_ena k%0d t=%0d got %b exp %b", k_sel, t, mem_ena_a[k_sel], e_acc); end
      checks++; if (mem_read_a[k_sel] !== erd) begin errors++;
        $display("FAIL mem_read k%0d t=%0d got %b exp %b", k_sel, t, mem_read_a[k_sel], erd); end
      checks++; if (mem_write_a[k_sel] !== ewr) begin errors++;
        $display("FAIL mem_write k%0d t=%0d got %b exp %b", k_sel, t, mem_write_a[k_sel], ewr); end
      if (e_acc || !rst) begin
        checks++; if (mem_addr_a[k_sel] !== eaddr) begin errors++;
          $display("FAIL mem_addr k%0d t=%0d got %h exp %h", k_sel, t, mem_addr_a[k_sel], eaddr); end
      end
      if (ewr || !rst) begin
        checks++; if (mem_wdata_a[k_sel] !== (ewr ? cd : 8'h00)) begin errors++;
          $display("FAIL mem_wdata k%0d t=%0d got %h exp %h", k_sel, t, mem_wdata_a[k_sel],
                   ewr ? cd : 8'h00); end
      end
      if (e_done || !rst) begin
        checks++; if (rdata_a[k_sel] !== exp_rd) begin errors++;
          $display("FAIL rdata k%0d t=%0d got %h exp %h", k_sel, t, rdata_a[k_sel], exp_rd); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic new_req(int i, logic we, logic lock);
    req_d[i]   = 1'b1;
    we_d[i]    = we;
    lock_d[i]  = lock;
    addr_d[i]  = 8'($urandom);
    wdata_d[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 1'b0; we_d[i] = 1'b0; lock_d[i] = 1'b0; addr_d[i] = 8'h00; wdata_d[i] = 8'h00;
    end
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    k_sel = 0; chk_en = 1;
    do_reset();
    repeat (20) tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({m0_gnt_a[k], m0_ack_a[k], m1_gnt_a[k], m1_ack_a[k], mem_ena_a[k], mem_read_a[k],
           mem_write_a[k], busy_a[k], rdata_a[k], mem_addr_a[k], mem_wdata_a[k]} !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle k%0d got busy=%b ena=%b rdata=%h exp all zero",
                 k, busy_a[k], mem_ena_a[k], rdata_a[k]);
      end
    end
  endtask

  // WAIT=1 read of 0x10, memory returns 0x5A.
  task automatic test_single_read();
    int cyc = 0, rd_cnt = 0, ack_cyc = -1, gnt_cyc = -1;
    logic [7:0] rd_at_ack = 8'h00;
    k_sel = 0;
    do_reset();
    new_req(0, 1'b0, 1'b0);
    addr_d[0] = 8'h10;
    while (ack_cyc < 0 && cyc < 20) begin
      tick(); cyc++;
      if (m0_gnt_a[0] && gnt_cyc < 0) gnt_cyc = cyc;
      if (mem_read_a[0]) rd_cnt++;
      if (m0_ack_a[0]) begin ack_cyc = cyc; rd_at_ack = rdata_a[0]; req_d[0] = 1'b0; end
    end
    checks++; if (gnt_cyc != 1) begin errors++;
      $display("FAIL rd_gnt_cycle got %0d exp 1", gnt_cyc); end
    checks++; if (rd_cnt != 2) begin errors++;
      $display("FAIL rd_strobe_len got %0d exp 2", rd_cnt); end
    checks++; if (ack_cyc != 3) begin errors++;
      $display("FAIL rd_ack_cycle got %0d exp 3", ack_cyc); end
    checks++; if (rd_at_ack !== 8'h5A) begin errors++;
      $display("FAIL rd_data got %h exp 5a", rd_at_ack); end
    repeat (3) tick();
  endtask

  // WAIT=0, both masters writing continuously.
  task automatic test_round_robin();
    int cyc = 0, n_ack = 0, wr_cnt = 0, lat_bad = 0, rise = -100;
    int order[4];
    logic busy_prev = 1'b0;
    k_sel = 1;
    do_reset();
    new_req(0, 1'b1, 1'b0);
    new_req(1, 1'b1, 1'b0);
    while (n_ack < 4 && cyc < 40) begin
      tick(); cyc++;
      if (busy_a[1] && !busy_prev) rise = cyc;
      busy_prev = busy_a[1];
      if (mem_write_a[1]) wr_cnt++;
      for (int i = 0; i < 2; i++) begin
        if ((i == 0 ? m0_ack_a[1] : m1_ack_a[1]) && n_ack < 4) begin
          order[n_ack] = i; n_ack++;
          if (cyc - rise != 1) lat_bad++;
          new_req(i, 1'b1, 1'b0);
        end
      end
    end
    req_d[0] = 1'b0; req_d[1] = 1'b0;
    checks++; if (n_ack != 4) begin errors++;
      $display("FAIL rr_timeout got %0d acks exp 4", n_ack); end
    for (int j = 0; j < n_ack; j++) begin
      checks++; if (order[j] != j % 2) begin errors++;
        $display("FAIL rr_order idx%0d got m%0d exp m%0d", j, order[j], j % 2); end
    end
    checks++; if (lat_bad != 0) begin errors++;
      $display("FAIL rr_ack_latency got %0d late acks exp 0", lat_bad); end
    checks++; if (wr_cnt != 4) begin errors++;
      $display("FAIL rr_write_pulses got %0d exp 4", wr_cnt); end
    repeat (4) tick();
  endtask

  // Async reset during an m1 write, then a tie after release.
  task automatic test_reset_mid();
    int cyc = 0, first = -1, n = 0;
    k_sel = 2;
    do_reset();
    new_req(1, 1'b1, 1'b0);
    while (!m1_gnt_a[2] && cyc < 5) begin tick(); cyc++; end
    repeat (5) tick();
    checks++; if (mem_write_a[2] !== 1'b1) begin errors++;
      $display("FAIL rst_pre_write got %b exp 1", mem_write_a[2]); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({m0_gnt_a[2], m1_gnt_a[2], m0_ack_a[2], m1_ack_a[2], mem_ena_a[2], mem_read_a[2],
         mem_write_a[2], busy_a[2]} !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got gnt1=%b wr=%b busy=%b ack1=%b exp 0",
               m1_gnt_a[2], mem_write_a[2], busy_a[2], m1_ack_a[2]);
    end
    checks++; if ({mem_addr_a[2], mem_wdata_a[2]} !== 16'h0) begin errors++;
      $display("FAIL rst_async_bus got %h/%h exp 0", mem_addr_a[2], mem_wdata_a[2]); end
    new_req(0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    cyc = 0;
    while (first < 0 && cyc < 10) begin
      tick(); cyc++;
      if (m0_gnt_a[2]) first = 0;
      else if (m1_gnt_a[2]) first = 1;
    end
    checks++; if (first != 0) begin errors++;
      $display("FAIL rst_first_winner got %0d exp 0", first); end
    while (n < 2 && cyc < 80) begin
      tick(); cyc++;
      if (m0_ack_a[2]) begin req_d[0] = 1'b0; n++; end
      if (m1_ack_a[2]) begin req_d[1] = 1'b0; n++; end
    end
    checks++; if (n != 2) begin errors++;
      $display("FAIL rst_post_acks got %0d exp 2", n); end
    repeat (2) tick();
  endtask

  // m1 issues 3 lock-flagged writes while m0 waits with a read.
  task automatic test_lock();
    int cyc = 0, n_ack = 0, n1 = 3, a1_first = -1, a1_last = -1;
    int order[4];
    int exp_ord[4];
    int exp_span;
`ifdef MEM_ARBITER_LOCK_EN
    exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 1; exp_ord[3] = 0;
    exp_span = 2 * (wait_of(0) + 2);
`else
    exp_ord[0] = 1; exp_ord[1] = 0; exp_ord[2] = 1; exp_ord[3] = 1;
    exp_span = 3 * (wait_of(0) + 3);
`endif
    k_sel = 0;
    do_reset();
    new_req(1, 1'b1, 1'b1);
    tick(); cyc++;
    new_req(0, 1'b0, 1'b0);
    while (n_ack < 4 && cyc < 100) begin
      tick(); cyc++;
      if (m0_ack_a[0] && n_ack < 4) begin
        order[n_ack] = 0; n_ack++; req_d[0] = 1'b0;
      end
      if (m1_ack_a[0] && n_ack < 4) begin
        order[n_ack] = 1; n_ack++; n1--;
        if (a1_first < 0) a1_first = cyc;
        a1_last = cyc;
        if (n1 > 0) new_req(1, 1'b1, 1'b1);
        else req_d[1] = 1'b0;
      end
    end
    checks++; if (n_ack != 4) begin errors++;
      $display("FAIL lock_timeout got %0d acks exp 4", n_ack); end
    for (int j = 0; j < n_ack; j++) begin
      checks++; if (order[j] != exp_ord[j]) begin errors++;
        $display("FAIL lock_order idx%0d got m%0d exp m%0d", j, order[j], exp_ord[j]); end
    end
    checks++; if (a1_last - a1_first != exp_span) begin errors++;
      $display("FAIL lock_span got %0d exp %0d", a1_last - a1_first, exp_span); end
    repeat (3) tick();
  endtask

  // WAIT=15 read with the request dropped mid-access.
  task automatic test_wait15_drop();
    int cyc = 0, st_cnt = 0, ack_cyc = -1;
    logic [7:0] a, rd_at_ack = 8'h00;
    k_sel = 2;
    do_reset();
    new_req(0, 1'b0, 1'b0);
    a = addr_d[0];
    while (ack_cyc < 0 && cyc < 40) begin
      tick(); cyc++;
      if (mem_read_a[2]) st_cnt++;
      if (cyc == 5) req_d[0] = 1'b0;
      if (m0_ack_a[2]) begin ack_cyc = cyc; rd_at_ack = rdata_a[2]; end
    end
    checks++; if (st_cnt != 16) begin errors++;
      $display("FAIL w15_strobe_len got %0d exp 16", st_cnt); end
    checks++; if (ack_cyc != 17) begin errors++;
      $display("FAIL w15_ack_cycle got %0d exp 17", ack_cyc); end
    checks++; if (rd_at_ack !== mem_f(a)) begin errors++;
      $display("FAIL w15_rdata got %h exp %h", rd_at_ack, mem_f(a)); end
    repeat (3) tick();
  endtask

  // Random traffic on every WAIT variant, checked cycle by cycle by the model.
  task automatic test_random();
    int cool[2];
    int m_ack, d_ack;
    bit mine;
    for (int k = 0; k < NI; k++) begin
      k_sel = k;
      do_reset();
      cool[0] = 0; cool[1] = 0; m_ack = 0; d_ack = 0;
      for (int c = 0; c < 400; c++) begin
        tick();
        if (e_done) m_ack++;
        if (m0_ack_a[k] || m1_ack_a[k]) d_ack++;
        for (int i = 0; i < 2; i++) begin
          mine = (own == i) && (e_acc || e_done);
          if (e_done && own == i) begin
            if ($urandom_range(0, 9) < 4) new_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else begin req_d[i] = 1'b0; cool[i] = $urandom_range(0, 3); end
          end else if (!req_d[i]) begin
            if (cool[i] > 0) cool[i]--;
            else if (!mine && $urandom_range(0, 9) < 6)
              new_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          end else if (mine && e_acc) begin
            // Attributes are free to change once the grant edge has passed.
            addr_d[i] = 8'($urandom); wdata_d[i] = 8'($urandom); we_d[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) req_d[i] = 1'b0;
          end
        end
      end
      checks++; if (d_ack != m_ack || m_ack == 0) begin errors++;
        $display("FAIL rand_ack_count k%0d got %0d exp %0d", k, d_ack, m_ack); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 1'b0; we_d[i] = 1'b0; lock_d[i] = 1'b0; addr_d[i] = 8'h00; wdata_d[i] = 8'h00;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_reset_mid();
    test_lock();
    test_wait15_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and access sequencer for the CPU's shared 8-bit memory bus. It lets the core's fetch/execute path (master 0) and an external loader/debug port (master 1) take turns on one RAM/ROM address/data path. It grants the bus round-robin, drives the memory enable and read/write strobes for a parameterised number of wait states, captures read data, and returns a one-cycle acknowledge to the winning master.

## Interface
Parameters:
- WAIT, 1: extra access cycles after the first; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 access type: 1 = write, 0 = read.
- m0_addr  in  8  master 0 address.
- m0_wdata  in  8  master 0 write data.
- m0_lock  in  1  master 0 keeps the bus after this access (see Configuration).
- m0_gnt  out  1  master 0 owns the bus for the current access.
- m0_ack  out  1  one-cycle pulse when the master 0 access completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_ack: same as master 0, for master 1.
- rdata  out  8  read data of the last completed read; valid in the ack cycle.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data.
- mem_ena  out  1  memory enable.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  arbiter is not in IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE
  - With no request, stay in IDLE.
  - If one master requests, grant it.
  - If both request, grant the master that did not win the previous grant. `last` is a 1-bit pointer; it resets to 1, so master 0 wins the first tie.
  - On a grant: register addr, we and wdata from the winner, set that master's gnt, update `last`, load `cnt` = WAIT, then go to ACCESS.
- ACCESS
  - Drive mem_ena = 1 and mem_addr/mem_wdata from the registered values.
  - Drive mem_read = ~we and mem_write = we.
  - While cnt != 0, decrement cnt.
  - When cnt == 0: if this is a read, latch mem_rdata into rdata; go to DONE.
- DONE
  - All mem strobes are 0. Pulse the owner's ack; gnt stays high during this cycle.
  - Next state is IDLE, or the locked path described in Configuration.
  - Clear gnt on exit to IDLE.
- Only one gnt is ever high. ack is only asserted together with the matching gnt.
- A request dropped during ACCESS does not abort the access; the ack is still issued.
- Inputs on m*_addr/we/wdata are don't-care after the grant edge.
- Writes never modify rdata.

## Timing
- Reset (rst = 0) is asynchronous:
  - State goes to IDLE immediately, cnt = 0, last = 1, rdata = 0.
  - All gnt, ack, mem_*, busy outputs = 0; mem_addr = 0 and mem_wdata = 0.
  - A reset in the middle of an access aborts it with no ack.
- Let edge E be the rising edge where IDLE samples a request.
  - gnt, busy and mem_ena rise after E.
  - mem strobes are high for exactly WAIT+1 cycles.
  - ack is high in cycle WAIT+2 after E.
  - Request-to-ack latency = WAIT+2 cycles; a full access occupies WAIT+3 cycles including the return to IDLE.
- Back-to-back: IDLE lasts one cycle between accesses. If a request is pending, it is granted on that IDLE edge.
- Under continuous requests from both masters, grants alternate 0,1,0,1,...

## Configuration
- Macro: MEM_ARBITER_LOCK_EN.
- Defined:
  - If the owner's lock = 1 in the DONE cycle and its req is still high, go straight to ACCESS for the same master without a pass through IDLE.
  - In that case, resample addr/we/wdata, reload cnt and keep gnt high; `last` is unchanged.
  - Lock is re-evaluated at each DONE.
  - A locked back-to-back access takes WAIT+2 cycles per transfer.
- Undefined: the m*_lock ports exist but are ignored; DONE always returns to IDLE.

## Test plan
- Reset, then apply no requests: all outputs 0, busy = 0, indefinitely.
- WAIT = 1, m0 reads addr 0x10 with memory returning 0x5A:
  - m0_gnt rises after edge 1.
  - mem_read is high for 2 cycles.
  - m0_ack is high in cycle 3 with rdata = 0x5A.
- WAIT = 0, m0 and m1 request continuously, both writing: grant order is 0,1,0,1; each ack arrives 2 cycles after its grant edge; each mem_write is a 1-cycle pulse.
- rst = 0 in the middle of ACCESS during an m1 write: all strobes and gnt fall asynchronously, no m1_ack. After reset release with both masters requesting, m0 wins first.
- With MEM_ARBITER_LOCK_EN defined, m1 issues 3 locked writes while m0 requests: m1 gets 3 consecutive accesses with no IDLE between them, then m0 is granted on the next IDLE.
- WAIT = 15: strobes are high for 16 cycles and ack arrives on cycle 17. Dropping m0_req in the middle of the access still yields m0_ack.
